// File: rtl/ecc_check_sched.sv
// ecc_check_sched: round-robin arbiter sharing one SECDED check engine, with RAS event counters
module ecc_check_sched #(
  parameter int          NUM_REQ    = 4,
  parameter int          DWIDTH     = 64,
  parameter int          EWIDTH     = 8,
  parameter int          IDW        = $clog2(NUM_REQ),
  parameter int          TIMEOUT    = 16,
  parameter logic [15:0] DED_THRESH = 16'd8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ*EWIDTH-1:0] req_ecc,
  output logic                      eng_start,
  output logic [DWIDTH-1:0]         eng_data_o,
  output logic [EWIDTH-1:0]         eng_ecc_o,
  input  logic                      eng_done,
  input  logic [DWIDTH-1:0]         eng_data_i,
  input  logic                      eng_sec,
  input  logic                      eng_ded,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                      rsp_sec,
  output logic                      rsp_ded,
  output logic                      rsp_timeout,
  input  logic                      cnt_clr,
  output logic [15:0]               sec_cnt,
  output logic [15:0]               ded_cnt,
  output logic                      ded_irq
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [IDW-1:0]      r_rr, r_id, w_gnt, w_idx;
  logic [TW-1:0]       r_timer;
  logic [DWIDTH-1:0]   r_data, r_rsp_data;
  logic [EWIDTH-1:0]   r_ecc;
  logic                r_start, r_rsp_valid, r_rsp_sec, r_rsp_ded, r_rsp_to, r_irq;
  logic [IDW-1:0]      r_rsp_id;
  logic [15:0]         r_sec_cnt, r_ded_cnt, w_sec_nxt, w_ded_nxt;
  logic                w_found, w_take, w_done, w_to, w_fin, w_inc_sec, w_inc_ded;
  assign w_take      = rst_n && r_state == IDLE && cfg_en && w_found;
  assign w_done      = r_state == WAIT && eng_done;
  assign w_to        = r_state == WAIT && !eng_done && r_timer == TW'(TIMEOUT - 1);
  assign w_fin       = w_done || w_to;
  assign w_inc_sec   = w_done && eng_sec && !eng_ded;
  assign w_inc_ded   = (w_done && eng_ded) || w_to;
  assign w_sec_nxt   = (w_inc_sec && r_sec_cnt != 16'hFFFF) ? r_sec_cnt + 16'd1 : r_sec_cnt;
  assign w_ded_nxt   = (w_inc_ded && r_ded_cnt != 16'hFFFF) ? r_ded_cnt + 16'd1 : r_ded_cnt;
  assign req_ready   = w_take ? (NUM_REQ'(1) << w_gnt) : '0;
  assign eng_start   = r_start;
  assign eng_data_o  = r_data;
  assign eng_ecc_o   = r_ecc;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_sec     = r_rsp_sec;
  assign rsp_ded     = r_rsp_ded;
  assign rsp_timeout = r_rsp_to;
  assign sec_cnt     = r_sec_cnt;
  assign ded_cnt     = r_ded_cnt;
  assign ded_irq     = r_irq;
  // round-robin pick: scan downwards so the lowest offset from r_rr wins
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_rr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_take ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_fin ? RESP : WAIT;
      default: w_next = rsp_ready ? IDLE : RESP;
    endcase
  end
  // state, capture, engine launch and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_id        <= '0;
      r_timer     <= '0;
      r_start     <= 1'b0;
      r_data      <= '0;
      r_ecc       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_sec   <= 1'b0;
      r_rsp_ded   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_take;
      r_timer <= (r_state == WAIT) ? r_timer + 1'b1 : '0;
      if (w_take) begin
        r_rr   <= (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        r_id   <= w_gnt;
        r_data <= req_data[w_gnt*DWIDTH +: DWIDTH];
        r_ecc  <= req_ecc[w_gnt*EWIDTH +: EWIDTH];
      end
      if (w_fin) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_id;
        r_rsp_data  <= w_done ? eng_data_i : r_data;
        r_rsp_sec   <= w_inc_sec;
        r_rsp_ded   <= !w_done || eng_ded;
        r_rsp_to    <= !w_done;
      end else if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
  // saturating SEC/DED counters and sticky threshold interrupt; clear beats increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_sec_cnt <= w_sec_nxt;
      r_ded_cnt <= w_ded_nxt;
      r_irq     <= r_irq || w_ded_nxt >= DED_THRESH;
    end
  end
endmodule

// File: tb/tb_ecc_check_sched.sv
// tb_ecc_check_sched: directed self-checking bench for the shared ECC engine scheduler
module tb_ecc_check_sched;
  localparam int N = 4, DW = 64, EW = 8;
  logic            clk = 1'b0, rst_n = 1'b0, cfg_en = 1'b0, rsp_ready = 1'b0, cnt_clr = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*EW-1:0] req_ecc = '0;
  logic            eng_start, eng_done, eng_sec, eng_ded;
  logic [DW-1:0]   eng_data_o, eng_data_i, rsp_data;
  logic [EW-1:0]   eng_ecc_o;
  logic            rsp_valid, rsp_sec, rsp_ded, rsp_timeout, ded_irq;
  logic [1:0]      rsp_id;
  logic [15:0]     sec_cnt, ded_cnt;
  int              e_delay = -1;
  logic [DW-1:0]   e_data = '0;
  logic            e_sec = 1'b0, e_ded = 1'b0, e_pulse = 1'b0, e_stray = 1'b0;
  int              checks = 0, failures = 0;
  assign eng_done   = e_pulse | e_stray;
  assign eng_data_i = e_data;
  assign eng_sec    = e_sec;
  assign eng_ded    = e_ded;
  ecc_check_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_ecc(req_ecc),
    .eng_start(eng_start), .eng_data_o(eng_data_o), .eng_ecc_o(eng_ecc_o),
    .eng_done(eng_done), .eng_data_i(eng_data_i), .eng_sec(eng_sec), .eng_ded(eng_ded),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_sec(rsp_sec), .rsp_ded(rsp_ded), .rsp_timeout(rsp_timeout),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_irq(ded_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // engine model: answers e_delay cycles after eng_start; negative delay never answers
  initial begin
    forever begin
      step();
      if (eng_start && e_delay >= 0) begin
        repeat (e_delay) step();
        e_pulse = 1'b1;
        step();
        e_pulse = 1'b0;
      end
    end
  end
  task automatic txn(input int id, input logic [63:0] d, input logic [7:0] e, input int dly,
                     input logic s, input logic dd, input logic clr);
    int k;
    e_delay = dly;
    e_data  = ~d;
    e_sec   = s;
    e_ded   = dd;
    req_data[id*DW +: DW] = d;
    req_ecc[id*EW +: EW]  = e;
    req_valid = N'(1) << id;
    #1;
    k = 0;
    while (req_ready == '0 && k < 12) begin
      step();
      k++;
    end
    chk("grant", 64'(req_ready), 64'(N'(1) << id));
    step();
    chk("ready_pulse", 64'(req_ready), '0);
    req_valid = '0;
    chk("eng_start", 64'(eng_start), 64'd1);
    chk("eng_data", eng_data_o, d);
    chk("eng_ecc", 64'(eng_ecc_o), 64'(e));
    k = 0;
    while (!rsp_valid && k < 40) begin
      cnt_clr = clr && k == dly;
      step();
      cnt_clr = 1'b0;
      k++;
    end
    chk("latency", 64'(k), 64'(dly < 0 ? 17 : dly + 1));
    chk("rsp_id", 64'(rsp_id), 64'(id));
    chk("rsp_data", rsp_data, dly < 0 ? d : ~d);
    chk("rsp_sec", 64'(rsp_sec), 64'(dly >= 0 && s && !dd));
    chk("rsp_ded", 64'(rsp_ded), 64'(dly < 0 || dd));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(dly < 0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    int n, cyc, last;
    cfg_en = 1'b1;
    req_valid = '1;
    repeat (3) step();
    chk("rst_ready", 64'(req_ready), '0);
    chk("rst_valid", 64'(rsp_valid), '0);
    chk("rst_start", 64'(eng_start), '0);
    chk("rst_eng_data", eng_data_o, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_sec_cnt", 64'(sec_cnt), '0);
    chk("rst_ded_cnt", 64'(ded_cnt), '0);
    chk("rst_irq", 64'(ded_irq), '0);
    req_valid = '0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'(i + 1) << 40;
    e_delay = 1;
    e_data = 64'hA5A5;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    n = 0;
    cyc = 0;
    last = 0;
    while (n < 5 && cyc < 30) begin
      if (req_ready != '0) begin
        chk("rr_grant", 64'(req_ready), 64'(N'(1) << (n % N)));
        if (n > 0) chk("rr_gap", 64'(cyc - last), 64'd4);
        last = cyc;
        n++;
      end
      if (rsp_valid) chk("rr_rsp_id", 64'(rsp_id), 64'((n - 1) % N));
      step();
      cyc++;
    end
    chk("rr_count", 64'(n), 64'd5);
    req_valid = '0;
    repeat (3) step();
    chk("rr_sec_cnt", 64'(sec_cnt), '0);
    txn(2, 64'h0123456789ABCDEF, 8'h5A, 1, 1'b1, 1'b0, 1'b0);
    chk("single_sec_cnt", 64'(sec_cnt), 64'd1);
    txn(0, 64'hDEADBEEFCAFEF00D, 8'hC3, -1, 1'b0, 1'b0, 1'b0);
    chk("to_ded_cnt", 64'(ded_cnt), 64'd1);
    chk("to_sec_cnt", 64'(sec_cnt), 64'd1);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sec_cnt", 64'(sec_cnt), '0);
    chk("clr_ded_cnt", 64'(ded_cnt), '0);
    cfg_en = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("cfg_block", 64'(req_ready), '0);
    step();
    chk("cfg_block_start", 64'(eng_start), '0);
    req_valid = '0;
    cfg_en = 1'b1;
    rsp_ready = 1'b0;
    txn(3, 64'h5555AAAA5555AAAA, 8'h0F, 2, 1'b1, 1'b1, 1'b0);
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", rsp_data, ~64'h5555AAAA5555AAAA);
      chk("bp_ready", 64'(req_ready), '0);
    end
    chk("bp_ded_cnt", 64'(ded_cnt), 64'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release", 64'(rsp_valid), '0);
    for (int i = 2; i <= 8; i++) begin
      txn(i % N, 64'(i) * 64'h0101010101010101, 8'(i), 1, 1'b0, 1'b1, 1'b0);
      chk("thr_ded_cnt", 64'(ded_cnt), 64'(i));
      chk("thr_irq", 64'(ded_irq), 64'(i >= 8));
    end
    txn(1, 64'h0F0F0F0F0F0F0F0F, 8'h11, 1, 1'b0, 1'b1, 1'b1);
    chk("clr_win_ded_cnt", 64'(ded_cnt), '0);
    chk("clr_win_irq", 64'(ded_irq), '0);
    step();
    force dut.r_sec_cnt = 16'hFFFE;
    step();
    release dut.r_sec_cnt;
    step();
    chk("sat_pre", 64'(sec_cnt), 64'hFFFE);
    txn(2, 64'h1234, 8'h22, 1, 1'b1, 1'b0, 1'b0);
    chk("sat_max", 64'(sec_cnt), 64'hFFFF);
    txn(3, 64'h5678, 8'h33, 1, 1'b1, 1'b0, 1'b0);
    chk("sat_hold", 64'(sec_cnt), 64'hFFFF);
    step();
    e_delay = -1;
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 64'(rsp_valid), '0);
    chk("mid_rst_start", 64'(eng_start), '0);
    chk("mid_rst_eng_data", eng_data_o, '0);
    chk("mid_rst_eng_ecc", 64'(eng_ecc_o), '0);
    chk("mid_rst_sec_cnt", 64'(sec_cnt), '0);
    chk("mid_rst_ded_cnt", 64'(ded_cnt), '0);
    rst_n = 1'b1;
    e_sec = 1'b1;
    e_stray = 1'b1;
    step();
    e_stray = 1'b0;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (rsp_valid) n++;
    end
    chk("stray_no_rsp", 64'(n), '0);
    chk("stray_sec_cnt", 64'(sec_cnt), '0);
    req_valid = 4'b1010;
    #1;
    chk("rr_after_rst", 64'(req_ready), 64'h2);
    req_valid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ecc_check_sched.md
Name: ecc_check_sched

Overview:
Round-robin scheduler that shares one SECDED check/correct engine (64b data + 8b check) among NUM_REQ requesters on the RCD datapath.
It accepts one codeword per grant, launches the engine, and waits for its done with a timeout.
It returns the corrected result to the originating requester over a valid/ready response channel.
It also keeps saturating SEC/DED event counters and a sticky DED-threshold interrupt for RAS logging.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DWIDTH, 64, codeword data width
EWIDTH, 8, check-bit width
IDW, $clog2(NUM_REQ), requester id width
TIMEOUT, 16, max WAIT cycles before abort (>=2)
DED_THRESH, 16'd8, ded_cnt value that sets ded_irq

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  synchronous active-low reset
cfg_en  in  1  allow new grants
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*DWIDTH  packed data; requester i at [i*DWIDTH +: DWIDTH]
req_ecc  in  NUM_REQ*EWIDTH  packed check bits
eng_start  out  1  one-cycle engine launch pulse
eng_data_o  out  DWIDTH  data to engine
eng_ecc_o  out  EWIDTH  check bits to engine
eng_done  in  1  engine result valid (single-cycle pulse)
eng_data_i  in  DWIDTH  corrected data from engine
eng_sec  in  1  engine single-error flag
eng_ded  in  1  engine double-error flag
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  originating requester
rsp_data  out  DWIDTH  corrected, or raw on timeout
rsp_sec  out  1  single error corrected
rsp_ded  out  1  uncorrectable error
rsp_timeout  out  1  engine did not answer
cnt_clr  in  1  clear counters and irq
sec_cnt  out  16  saturating SEC count
ded_cnt  out  16  saturating DED+timeout count
ded_irq  out  1  sticky threshold interrupt

Behaviour:
- Reset (rst_n low at a clock edge) forces the following, regardless of state, and aborts any in-flight transaction with no response:
  - state=IDLE, rr_ptr=0.
  - All registered outputs 0: eng_start, eng_data_o, eng_ecc_o, rsp_*, sec_cnt, ded_cnt, ded_irq.
  - req_ready=0 while in reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If cfg_en=1 and any req_valid, grant g = first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle only; the handshake completes that cycle.
  - Capture data/ecc/id of g; rr_ptr <= (g+1) mod NUM_REQ; go to ISSUE.
  - req_ready=0 in all other states and when cfg_en=0.
- ISSUE: eng_start=1 for exactly one cycle; timer<=0; go to WAIT.
  - eng_data_o/eng_ecc_o are driven from the capture registers and held stable from ISSUE through the end of WAIT.
- WAIT:
  - eng_done is sampled only in WAIT; eng_done in any other state is ignored.
  - eng_done=1: register eng_data_i/eng_sec/eng_ded into rsp_*, rsp_timeout=0, go to RESP.
  - Else, if timer==TIMEOUT-1: rsp_data=captured raw data, rsp_sec=0, rsp_ded=1, rsp_timeout=1, go to RESP.
  - Else timer++.
  - If eng_sec and eng_ded are both 1, treat as DED (rsp_sec=0).
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1, then rsp_valid<=0 and go to IDLE.
- Latency: request handshake at cycle T -> eng_start T+1 -> earliest done T+2 -> rsp_valid T+3. Minimum 4 cycles per transaction.
- cfg_en=0 only blocks new grants in IDLE; an in-flight transaction completes normally.
- Counters update on the WAIT->RESP transition:
  - rsp_sec -> sec_cnt+1.
  - rsp_ded or timeout -> ded_cnt+1.
  - Both counters saturate at 16'hFFFF.
- ded_irq is set when ded_cnt becomes >= DED_THRESH and stays set.
- cnt_clr=1 zeroes sec_cnt, ded_cnt and ded_irq, and has priority over a same-cycle increment (that increment is lost).

Test Plan:
- Single request: req_valid[2]=1, data=64'h0123456789ABCDEF; engine done after 1 cycle with sec=1 -> req_ready[2] pulses 1 cycle, eng_start at T+1, rsp_valid at T+3 with rsp_id=2, rsp_sec=1; sec_cnt=1.
- Round-robin fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 4 cycles; no requester skipped.
- Timeout: eng_done never asserted, TIMEOUT=16 -> rsp_valid 16 cycles after eng_start+1 with rsp_timeout=1, rsp_ded=1, rsp_data=raw captured data; ded_cnt=1.
- Backpressure plus threshold: rsp_ready=0 for 10 cycles -> rsp_* stable, no req_ready; then eight DED responses -> ded_irq=1 after the 8th; cnt_clr coincident with a 9th DED -> ded_cnt=0, ded_irq=0.
- Saturation: preload 65535 SEC events -> the next SEC leaves sec_cnt=16'hFFFF.
- Reset mid-WAIT: rst_n=0 for one edge -> IDLE, all outputs 0, no response emitted, rr_ptr=0; a stray eng_done after reset is ignored.
